word_rmw_arbiter: RTL and testbench

Shared store of DEPTH packed 16-bit words, each laid out as {high[7:0], low[7:0]}. Two requesters issue reads and field-granular writes: whole word, high byte, low byte, or the straddling slice [11:4]. The block arbitrates round-robin between the requesters and sequences each write as read-modify-write, so untouched bits are preserved. It sits between packed-struct producers/consumers and the word storage.

---
 rtl/word_rmw_arbiter.sv | 134 +++++++++++++
 tb/tb_word_rmw_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/word_rmw_arbiter.sv
// Two-requester round-robin arbiter in front of a small word store.
// Every write is a read-modify-write at field granularity, so bits outside the field are kept.
module word_rmw_arbiter #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic          we0,
    input  logic [1:0]    fld0,
    input  logic [AW-1:0] addr0,
    input  logic [15:0]   wdata0,
    output logic          ack0,
    output logic [15:0]   rdata0,
    input  logic          req1,
    input  logic          we1,
    input  logic [1:0]    fld1,
    input  logic [AW-1:0] addr1,
    input  logic [15:0]   wdata1,
    output logic          ack1,
    output logic [15:0]   rdata1,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, RD, MRG, DONE} state_t;

    typedef struct packed {
        logic          owner;
        logic          we;
        logic [1:0]    fld;
        logic [AW-1:0] addr;
        logic [15:0]   wdata;
    } op_t;

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    state_t      r_state;
    state_t      w_next;
    op_t         r_op;
    op_t         w_req_op;
    logic [15:0] r_hold;
    logic [15:0] r_mem [DEPTH];
    logic [15:0] r_rdata0;
    logic [15:0] r_rdata1;
    logic        r_last;
    logic [1:0]  w_req;
    logic        w_grant_vld;
    logic        w_grant_sel;
    logic        w_in_range;
    logic [15:0] w_merged;

    assign w_req       = {req1, req0};
    assign w_grant_vld = |w_req;
    // On a tie the requester that did not win last time gets the grant.
    assign w_grant_sel = (&w_req) ? ~r_last : w_req[1];
    assign w_in_range  = {1'b0, r_op.addr} < DEPTH_W;

    always_comb begin
        w_req_op = '0;
        if (w_grant_sel) begin
            w_req_op = '{owner: 1'b1, we: we1, fld: fld1, addr: addr1, wdata: wdata1};
        end else begin
            w_req_op = '{owner: 1'b0, we: we0, fld: fld0, addr: addr0, wdata: wdata0};
        end
    end

    // Only wdata[7:0] reaches the narrow fields; the upper byte is dropped.
    always_comb begin
        w_merged = r_hold;
        case (r_op.fld)
            2'b00: w_merged = r_op.wdata;
            2'b01: w_merged = {r_op.wdata[7:0], r_hold[7:0]};
            2'b10: w_merged = {r_hold[15:8], r_op.wdata[7:0]};
            2'b11: w_merged = {r_hold[15:12], r_op.wdata[7:0], r_hold[3:0]};
            default: w_merged = r_hold;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (w_grant_vld) w_next = RD;
            RD:   w_next = r_op.we ? MRG : DONE;
            MRG:  w_next = DONE;
            DONE: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op     <= '0;
            r_hold   <= '0;
            r_last   <= 1'b1;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant_vld) begin
                        r_op   <= w_req_op;
                        r_last <= w_grant_sel;
                    end
                end
                RD:  r_hold <= w_in_range ? r_mem[r_op.addr] : 16'h0000;
                MRG: r_hold <= w_merged;
                DONE: begin
                    // Out-of-range writes still complete but never touch storage.
                    if (r_op.we && w_in_range) r_mem[r_op.addr] <= r_hold;
                    if (r_op.owner) r_rdata1 <= r_hold;
                    else            r_rdata0 <= r_hold;
                end
                default: ;
            endcase
        end
    end

    assign ack0   = (r_state == DONE) && !r_op.owner;
    assign ack1   = (r_state == DONE) &&  r_op.owner;
    assign rdata0 = ack0 ? r_hold : r_rdata0;
    assign rdata1 = ack1 ? r_hold : r_rdata1;
    assign busy   = (r_state != IDLE);

endmodule

// File: tb/tb_word_rmw_arbiter.sv
// Randomized and directed bench for word_rmw_arbiter, checked every cycle against a
// transaction-level model of the store plus literal expectations for the directed steps.
module tb_word_rmw_arbiter;

    localparam int DEPTH = 3;
    localparam int AW    = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0, we0, req1, we1;
    logic [1:0]    fld0, fld1;
    logic [AW-1:0] addr0, addr1;
    logic [15:0]   wdata0, wdata1;
    logic          ack0, ack1, busy;
    logic [15:0]   rdata0, rdata1;

    int n_chk = 0;
    int n_err = 0;
    int ack_q[$];

    always #5 clk = ~clk;

    word_rmw_arbiter #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .we0(we0), .fld0(fld0), .addr0(addr0), .wdata0(wdata0),
        .ack0(ack0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .fld1(fld1), .addr1(addr1), .wdata1(wdata1),
        .ack1(ack1), .rdata1(rdata1),
        .busy(busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] merge(input logic [15:0] old, input logic [1:0] f,
                                          input logic [15:0] wd);
        case (f)
            2'd0:    return wd;
            2'd1:    return {wd[7:0], old[7:0]};
            2'd2:    return {old[15:8], wd[7:0]};
            default: return {old[15:12], wd[7:0], old[3:0]};
        endcase
    endfunction

    // Transaction model: an op is granted in an idle cycle and occupies the block for
    // 2 (read) or 3 (write) cycles; its ack appears in the last of those cycles.
    int          m_cnt, m_own, m_last;
    logic        m_we;
    int          m_addr;
    logic [15:0] m_res;
    logic [15:0] m_mem [4];
    logic [15:0] m_rd  [2];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt = 0; m_last = 1; m_own = 0; m_we = 0; m_addr = 0; m_res = 0;
            m_rd[0] = 0; m_rd[1] = 0;
            for (int i = 0; i < 4; i++) m_mem[i] = 0;
        end else if (m_cnt == 0) begin
            if (req0 || req1) begin
                logic [15:0] old;
                logic [1:0]  f;
                logic [15:0] wd;
                m_own  = (req0 && req1) ? 1 - m_last : (req0 ? 0 : 1);
                m_last = m_own;
                m_we   = m_own ? we1 : we0;
                m_addr = m_own ? int'(addr1) : int'(addr0);
                f      = m_own ? fld1 : fld0;
                wd     = m_own ? wdata1 : wdata0;
                old    = (m_addr < DEPTH) ? m_mem[m_addr] : 16'h0000;
                m_res  = m_we ? merge(old, f, wd) : old;
                m_cnt  = m_we ? 3 : 2;
            end
        end else begin
            if (m_cnt == 1) begin
                if (m_we && m_addr < DEPTH) m_mem[m_addr] = m_res;
                m_rd[m_own] = m_res;
            end
            m_cnt--;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            logic e0, e1;
            e0 = (m_cnt == 1) && (m_own == 0);
            e1 = (m_cnt == 1) && (m_own == 1);
            chk("ack0", 32'(ack0), 32'(e0));
            chk("ack1", 32'(ack1), 32'(e1));
            chk("rdata0", 32'(rdata0), 32'(e0 ? m_res : m_rd[0]));
            chk("rdata1", 32'(rdata1), 32'(e1 ? m_res : m_rd[1]));
            chk("busy", 32'(busy), 32'(m_cnt != 0));
        end
    end

    task automatic drive(input int r, input logic rq, input logic w, input logic [1:0] f,
                         input logic [AW-1:0] a, input logic [15:0] wd);
        if (r == 0) begin req0 = rq; we0 = w; fld0 = f; addr0 = a; wdata0 = wd; end
        else        begin req1 = rq; we1 = w; fld1 = f; addr1 = a; wdata1 = wd; end
    endtask

    // Called just after a rising edge; returns just after the edge that ends the ack cycle.
    // lat counts cycles from the one where req is first presented to the ack cycle.
    task automatic op(input int r, input logic w, input logic [1:0] f, input logic [AW-1:0] a,
                      input logic [15:0] wd, output logic [15:0] rd, output int lat);
        logic got = 1'b0;
        lat = 0;
        rd  = 16'h0;
        drive(r, 1'b1, w, f, a, wd);
        while (!got && lat < 40) begin
            @(negedge clk);
            lat++;
            if ((r == 0 && ack0) || (r == 1 && ack1)) begin
                got = 1'b1;
                rd  = (r == 0) ? rdata0 : rdata1;
                ack_q.push_back(r);
            end
        end
        if (!got) chk($sformatf("ack_timeout_r%0d", r), 32'(0), 32'(1));
        @(posedge clk);
        #1;
        drive(r, 1'b0, w, f, a, wd);
    endtask

    initial begin
        logic [15:0] rd, rd_a, rd_b;
        int          lat, lat_b;
        rst_n = 1'b0;
        drive(0, 1'b0, 1'b0, 2'd0, '0, '0);
        drive(1, 1'b0, 1'b0, 2'd0, '0, '0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", 32'(busy), 32'(0));
        chk("reset_ack", 32'({ack1, ack0}), 32'(0));
        chk("reset_rdata", 32'({rdata1, rdata0}), 32'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Read after reset: latency 2 counted from the sampling idle cycle.
        op(0, 1'b0, 2'd0, 2'd0, 16'h0, rd, lat);
        chk("rd0_data", 32'(rd), 32'h0000);
        chk("rd_latency", 32'(lat - 1), 32'd2);

        op(0, 1'b1, 2'd0, 2'd1, 16'hFFFF, rd, lat);
        chk("wr_whole_data", 32'(rd), 32'hFFFF);
        chk("wr_latency", 32'(lat - 1), 32'd3);
        op(0, 1'b1, 2'd2, 2'd1, 16'h0100, rd, lat);
        chk("wr_low_trunc", 32'(rd), 32'hFF00);
        op(0, 1'b0, 2'd0, 2'd1, 16'h0, rd, lat);
        chk("rd_addr1", 32'(rd), 32'hFF00);

        op(1, 1'b1, 2'd3, 2'd2, 16'h00FF, rd, lat);
        chk("wr_slice", 32'(rd), 32'h0FF0);
        op(1, 1'b1, 2'd1, 2'd2, 16'h007F, rd, lat);
        chk("wr_high", 32'(rd), 32'h7FF0);
        op(1, 1'b0, 2'd0, 2'd2, 16'h0, rd, lat);
        chk("rd_addr2", 32'(rd), 32'h7FF0);

        // Contending writers on one word: grants alternate, starting with requester 0.
        ack_q.delete();
        fork
            begin
                op(0, 1'b1, 2'd1, 2'd2, 16'h0012, rd_a, lat);
                op(0, 1'b1, 2'd2, 2'd2, 16'h5634, rd_a, lat);
            end
            begin
                op(1, 1'b1, 2'd3, 2'd2, 16'h00AB, rd_b, lat_b);
                op(1, 1'b1, 2'd1, 2'd2, 16'h00CD, rd_b, lat_b);
            end
        join
        chk("tie_order", 32'({ack_q.size() == 4 ? ack_q[0] : 9, ack_q.size() == 4 ? ack_q[1] : 9,
                              ack_q.size() == 4 ? ack_q[2] : 9, ack_q.size() == 4 ? ack_q[3] : 9}),
            32'({0, 1, 0, 1}));
        chk("tie_r0_last", 32'(rd_a), 32'h1A34);
        chk("tie_r1_last", 32'(rd_b), 32'hCD34);
        op(0, 1'b0, 2'd0, 2'd2, 16'h0, rd, lat);
        chk("tie_final", 32'(rd), 32'hCD34);

        // Out-of-range write is acked, returns the merged value, and is not stored.
        op(1, 1'b1, 2'd0, 2'd3, 16'h1234, rd, lat);
        chk("oor_wr_rdata", 32'(rd), 32'h1234);
        op(1, 1'b0, 2'd0, 2'd3, 16'h0, rd, lat);
        chk("oor_rd", 32'(rd), 32'h0000);

        // Reset in the middle of a write: nothing is stored, nothing is acked.
        drive(0, 1'b1, 1'b1, 2'd0, 2'd0, 16'hAAAA);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_ack", 32'({ack1, ack0}), 32'(0));
        chk("rst_mid_busy", 32'(busy), 32'(0));
        drive(0, 1'b0, 1'b0, 2'd0, 2'd0, 16'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        ack_q.delete();
        fork
            op(0, 1'b0, 2'd0, 2'd0, 16'h0, rd_a, lat);
            op(1, 1'b0, 2'd0, 2'd1, 16'h0, rd_b, lat_b);
        join
        chk("rst_tie_first", 32'(ack_q.size() > 0 ? ack_q[0] : 9), 32'(0));
        chk("rst_addr0", 32'(rd_a), 32'h0000);

        // Random traffic from both requesters, checked by the cycle compare process.
        fork
            for (int k = 0; k < 60; k++) begin
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
                op(0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                   AW'($urandom_range(0, 3)), 16'($urandom), rd_a, lat);
            end
            for (int k = 0; k < 60; k++) begin
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
                op(1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                   AW'($urandom_range(0, 3)), 16'($urandom), rd_b, lat_b);
            end
        join

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
